// File: rtl/axi_stream_split_pkg.sv
// axi_stream_split_pkg: shared types and sizing helpers for the wide-to-narrow stream splitter.
//  split_state_e : EMPTY (no beat held) / SEND (serialising a held beat)
//  ceil_div      : integer ceiling division, used to derive the slice count
//  idx_width     : slice-index width, never below 1 bit
package axi_stream_split_pkg;
    typedef enum logic {EMPTY, SEND} split_state_e;
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction
endpackage

// File: rtl/axi_stream_wide_split.sv
// axi_stream_wide_split: serialises each wide AXI-Stream beat into RATIO narrow beats, zero-bubble.
//  aclk, aresetn (async active-low), aclken (freezes all state and handshakes when low)
//  in_tdata/in_tvalid/in_tlast/in_tready    : wide input beat, zero-padded to RATIO*ODSIZE
//  out_tdata/out_tvalid/out_tlast/out_tready : narrow slices; out_tlast only on final slice of a tlast beat
module axi_stream_wide_split
    import axi_stream_split_pkg::*;
#(
    parameter int IDSIZE    = 95,
    parameter int ODSIZE    = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    input  logic [IDSIZE-1:0] in_tdata,
    input  logic              in_tvalid,
    input  logic              in_tlast,
    output logic              in_tready,
    output logic [ODSIZE-1:0] out_tdata,
    output logic              out_tvalid,
    output logic              out_tlast,
    input  logic              out_tready
);
    localparam int RATIO = ceil_div(IDSIZE, ODSIZE);
    localparam int IDX_W = idx_width(RATIO);
    localparam int BW    = RATIO * ODSIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    split_state_e                  state_q;
    logic [RATIO-1:0][ODSIZE-1:0]  data_q;
    logic                          last_q;
    logic [IDX_W-1:0]              idx_q;
    logic [IDX_W-1:0]              sel;
    logic                          full;
    logic                          last_slice;
    logic                          in_fire;
    logic                          out_fire;
    // Ready opens on the final slice so the next beat reloads with no bubble.
    always_comb begin
        full       = state_q == SEND;
        last_slice = idx_q == LAST_IDX;
        sel        = LSB_FIRST ? idx_q : LAST_IDX - idx_q;
        in_tready  = aresetn & aclken & (!full | (out_tready & last_slice));
        in_fire    = in_tvalid & in_tready;
        out_fire   = full & out_tready & aclken;
        out_tvalid = full;
        out_tdata  = data_q[sel];
        out_tlast  = full & last_q & last_slice;
    end
    // A load while full can only happen together with the final-slice fire, so it takes priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else if (in_fire) begin
            state_q <= SEND;
            data_q  <= BW'(in_tdata);
            last_q  <= in_tlast;
            idx_q   <= '0;
        end else if (out_fire) begin
            state_q <= last_slice ? EMPTY : SEND;
            idx_q   <= last_slice ? '0 : idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_stream_wide_split.sv
// tb_axi_stream_wide_split: self-checking bench for axi_stream_wide_split (95 -> 3 x 32, LSB first).
module tb_axi_stream_wide_split;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        aclken;
    logic [94:0] in_tdata;
    logic        in_tvalid;
    logic        in_tlast;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    typedef struct packed {
        logic [94:0]      data;
        logic             last;
        logic [2:0][31:0] slc;
    } vec_t;
    vec_t tbl [6];

    axi_stream_wide_split #(.IDSIZE(95), .ODSIZE(32), .LSB_FIRST(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        tbl[0] = '{95'h7FFF_FFFF_1234_5678_9ABC_DEF0, 1'b1, {32'h7FFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0}};
        tbl[1] = '{95'h0, 1'b0, {32'h0, 32'h0, 32'h0}};
        tbl[2] = '{95'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, {32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}};
        tbl[3] = '{95'h0000_0001_0000_0000_0000_0000, 1'b0, {32'h0000_0001, 32'h0, 32'h0}};
        tbl[4] = '{95'h4000_0000_DEAD_BEEF_0BAD_F00D, 1'b1, {32'h4000_0000, 32'hDEAD_BEEF, 32'h0BAD_F00D}};
        tbl[5] = '{95'h1_CAFE_BABE_0000_0001, 1'b1, {32'h0000_0001, 32'hCAFE_BABE, 32'h0000_0001}};

        // Reset with valid asserted.
        aresetn = 1'b0; aclken = 1'b1; in_tvalid = 1'b1; in_tlast = 1'b1;
        in_tdata = tbl[0].data; out_tready = 1'b1;
        repeat (3) tick();
        check("rst_in_tready", in_tready, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_tlast", out_tlast, 0);
        in_tvalid = 1'b0;
        aresetn = 1'b1;
        tick();
        check("post_rst_in_tready", in_tready, 1);
        check("post_rst_out_tvalid", out_tvalid, 0);

        // Single tlast beat, one slice per cycle.
        in_tvalid = 1'b1; in_tdata = tbl[0].data; in_tlast = 1'b1;
        tick();
        in_tvalid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("single_valid", out_tvalid, 1);
            check("single_data", out_tdata, tbl[0].slc[k]);
            check("single_last", out_tlast, k == 2);
            check("single_in_tready", in_tready, k == 2);
            tick();
        end
        check("single_drained", out_tvalid, 0);

        // Stall: held beat must not move while out_tready is low.
        in_tvalid = 1'b1; in_tdata = tbl[4].data; in_tlast = 1'b0;
        tick();
        in_tvalid = 1'b0; out_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_valid", out_tvalid, 1);
            check("stall_data", out_tdata, tbl[4].slc[0]);
            check("stall_in_tready", in_tready, 0);
            tick();
        end
        out_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_resume_data", out_tdata, tbl[4].slc[k]);
            check("stall_resume_last", out_tlast, 0);
            tick();
        end

        // Clock enable low for 5 cycles while on slice 1.
        in_tvalid = 1'b1; in_tdata = tbl[5].data; in_tlast = 1'b1;
        tick();
        in_tvalid = 1'b0;
        #1;
        check("en_slice0", out_tdata, tbl[5].slc[0]);
        tick();
        aclken = 1'b0; in_tvalid = 1'b1; in_tdata = tbl[2].data;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("en_hold_data", out_tdata, tbl[5].slc[1]);
            check("en_hold_valid", out_tvalid, 1);
            check("en_in_tready", in_tready, 0);
            tick();
        end
        aclken = 1'b1; in_tvalid = 1'b0;
        #1;
        check("en_resume_s1", out_tdata, tbl[5].slc[1]);
        tick();
        check("en_resume_s2", out_tdata, tbl[5].slc[2]);
        check("en_resume_last", out_tlast, 1);
        tick();
        check("en_drained", out_tvalid, 0);

        // Asynchronous reset mid-beat, then a fresh beat from slice 0.
        in_tvalid = 1'b1; in_tdata = tbl[3].data; in_tlast = 1'b1;
        tick();
        in_tvalid = 1'b0;
        tick();
        check("mid_idx1", out_tdata, tbl[3].slc[1]);
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", out_tvalid, 0);
        check("mid_rst_ready", in_tready, 0);
        tick();
        aresetn = 1'b1;
        in_tvalid = 1'b1; in_tdata = 95'h2AAA_AAAA_AAAA_AAAA_AAAA_AAAA; in_tlast = 1'b0;
        tick();
        in_tvalid = 1'b0;
        #1;
        check("mid_new_s0", out_tdata, 32'hAAAA_AAAA);
        tick();
        check("mid_new_s1", out_tdata, 32'hAAAA_AAAA);
        tick();
        check("mid_new_s2", out_tdata, 32'h2AAA_AAAA);
        check("mid_new_last", out_tlast, 0);
        tick();

        // Back-to-back table beats with out_tready held high.
        begin
            int bi = 0, oi = 0, si = 0, cyc = 0, first = -1, lastc = 0, tl = 0;
            in_tvalid = 1'b1; in_tdata = tbl[0].data; in_tlast = tbl[0].last;
            while (oi < 6 && cyc < 100) begin
                #1;
                if (out_tvalid && out_tready) begin
                    if (first < 0) first = cyc;
                    lastc = cyc;
                    check("b2b_data", out_tdata, tbl[oi].slc[si]);
                    check("b2b_last", out_tlast, tbl[oi].last && si == 2);
                    if (out_tlast) tl++;
                    si++;
                    if (si == 3) begin si = 0; oi++; end
                end
                if (in_tvalid && in_tready) bi++;
                tick();
                cyc++;
                in_tvalid = bi < 6;
                in_tdata = tbl[bi < 6 ? bi : 0].data;
                in_tlast = tbl[bi < 6 ? bi : 0].last;
            end
            in_tvalid = 1'b0;
            check("b2b_all_out", oi, 6);
            check("b2b_no_gaps", lastc - first + 1, 18);
            check("b2b_tlast_count", tl, 4);
        end

        // Random handshakes against a scoreboard.
        begin
            logic [94:0] q_d [$];
            logic        q_l [$];
            logic [95:0] ext;
            logic [31:0] prev_data = '0;
            logic        prev_stall = 1'b0;
            logic        acc;
            int sent = 0, done = 0, si = 0, cyc = 0;
            while (done < 1000 && cyc < 40000) begin
                acc = 1'b0;
                if (!in_tvalid && sent < 1000 && $urandom_range(1, 0) == 1) begin
                    in_tvalid = 1'b1;
                    in_tdata = 95'({$urandom(), $urandom(), $urandom()});
                    in_tlast = 1'($urandom_range(1, 0));
                end
                out_tready = 1'($urandom_range(1, 0));
                #1;
                if (prev_stall) begin
                    check("rand_stall_valid", out_tvalid, 1);
                    check("rand_stall_data", out_tdata, prev_data);
                end
                if (out_tvalid && out_tready) begin
                    check("rand_out_has_beat", q_d.size() > 0, 1);
                    if (q_d.size() > 0) begin
                        ext = {1'b0, q_d[0]};
                        check("rand_data", out_tdata, ext[si*32 +: 32]);
                        check("rand_last", out_tlast, q_l[0] && si == 2);
                        si++;
                        if (si == 3) begin
                            si = 0; done++;
                            void'(q_d.pop_front());
                            void'(q_l.pop_front());
                        end
                    end
                end
                if (in_tvalid && in_tready) begin
                    q_d.push_back(in_tdata);
                    q_l.push_back(in_tlast);
                    sent++;
                    acc = 1'b1;
                end
                prev_stall = out_tvalid && !out_tready;
                prev_data = out_tdata;
                tick();
                cyc++;
                if (acc) in_tvalid = 1'b0;
            end
            check("rand_frames_done", done, 1000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
